// File: rtl/ws2812b_pkg.sv
// Shared constants, FSM encoding and pixel helpers for the WS2812B path.
// Timing constants are in 50 MHz clock cycles (20 ns each).
package ws2812b_pkg;

  localparam int NLEDS = 64;
  localparam int AW    = 6;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_SCALE = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam int T0H_CYC  = 20;
  localparam int T1H_CYC  = 40;
  localparam int TBIT_CYC = 63;
  localparam int TRST_CYC = 2800;

  function automatic logic [23:0] pack_grb(
    input logic [7:0] r,
    input logic [7:0] g,
    input logic [7:0] b
  );
    return {g, r, b};
  endfunction

  function automatic logic [7:0] scale8(
    input logic [7:0] c,
    input logic [7:0] br
  );
    logic [15:0] p;
    p = {8'd0, c} * ({8'd0, br} + 16'd1);
    return p[15:8];
  endfunction

endpackage

// File: rtl/ws2812b_pixel_buffer_if.sv
// Pixel stream handshake between the frame store and the serializer.
// The master drives pixels; the slave returns ready.
interface ws2812b_pixel_buffer_if;
  logic        pix_valid;
  logic        pix_ready;
  logic [23:0] pix_grb;
  logic        pix_last;

  modport master (
    output pix_valid,
    output pix_grb,
    output pix_last,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_grb,
    input  pix_last,
    output pix_ready
  );
endinterface

// File: rtl/ws2812b_dpram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Contents are not reset.
module ws2812b_dpram #(
  parameter int DEPTH = 128,
  parameter int ABITS = 7,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ABITS-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [ABITS-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ws2812b_pixel_buffer.sv
// Double-buffered pixel store streaming brightness-scaled GRB words
// to the WS2812B serializer, one pixel per READ/SCALE/OUT pass.
module ws2812b_pixel_buffer
  import ws2812b_pkg::*;
(
  input  logic                   CLOCK_50,
  input  logic                   RESET_N,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [23:0]            wr_rgb,
  input  logic                   commit,
  input  logic [7:0]             brightness,
  input  logic                   frame_start,
  ws2812b_pixel_buffer_if.master pix,
  output logic                   busy,
  output logic                   commit_pending
);

  logic [1:0]    state;
  logic [AW-1:0] idx;
  logic          front;
  logic          fs_hold;
  logic [7:0]    br;
  logic          valid_q;
  logic          last_q;
  logic [23:0]   grb_q;
  logic [23:0]   rdata;
  logic          swap;
  logic          start;
  logic          wr_ok;
  logic          at_last;

  assign swap    = commit_pending && (state == S_IDLE);
  assign start   = (state == S_IDLE) && (frame_start || fs_hold) && !swap;
  assign wr_ok   = wr_en && ({1'b0, wr_addr} < (AW+1)'(NLEDS));
  assign at_last = (idx == AW'(NLEDS - 1));

  ws2812b_dpram #(
    .DEPTH (2 * NLEDS),
    .ABITS (AW + 1),
    .WIDTH (24)
  ) u_ram (
    .clk   (CLOCK_50),
    .we    (wr_ok),
    .waddr ({~front, wr_addr}),
    .wdata (wr_rgb),
    .raddr ({front, idx}),
    .rdata (rdata)
  );

  assign pix.pix_valid = valid_q;
  assign pix.pix_grb   = grb_q;
  assign pix.pix_last  = last_q;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state          <= S_IDLE;
      idx            <= '0;
      front          <= 1'b0;
      fs_hold        <= 1'b0;
      br             <= '0;
      valid_q        <= 1'b0;
      last_q         <= 1'b0;
      grb_q          <= '0;
      busy           <= 1'b0;
      commit_pending <= 1'b0;
    end else begin
      if (swap) begin
        front          <= ~front;
        commit_pending <= 1'b0;
      end else if (commit) begin
        commit_pending <= 1'b1;
      end

      unique case (1'b1)
        (state == S_IDLE): begin
          // a request colliding with a swap is replayed next cycle
          if (swap && frame_start) fs_hold <= 1'b1;
          if (start) begin
            br      <= brightness;
            idx     <= '0;
            busy    <= 1'b1;
            fs_hold <= 1'b0;
            state   <= S_READ;
          end
        end
        (state == S_READ): begin
          state <= S_SCALE;
        end
        (state == S_SCALE): begin
          grb_q <= pack_grb(scale8(rdata[23:16], br),
                            scale8(rdata[15:8], br),
                            scale8(rdata[7:0], br));
          state <= S_OUT;
        end
        (state == S_OUT): begin
          if (!valid_q) begin
            valid_q <= 1'b1;
            last_q  <= at_last;
          end else if (pix.pix_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            if (at_last) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_READ;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812b_pixel_buffer.sv
// Scoreboard bench for the WS2812B pixel buffer.
// A bank-array model predicts each frame; a monitor checks handshakes.
module tb_ws2812b_pixel_buffer;
  import ws2812b_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [23:0]   wr_rgb = '0;
  logic          commit = 1'b0;
  logic [7:0]    brightness = '0;
  logic          frame_start = 1'b0;
  logic          busy;
  logic          commit_pending;

  ws2812b_pixel_buffer_if pix();

  ws2812b_pixel_buffer dut (
    .CLOCK_50       (clk),
    .RESET_N        (rst_n),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_rgb         (wr_rgb),
    .commit         (commit),
    .brightness     (brightness),
    .frame_start    (frame_start),
    .pix            (pix),
    .busy           (busy),
    .commit_pending (commit_pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  idx;
    logic        last;
    logic [23:0] grb;
  } exp_t;

  exp_t        q[$];
  logic [23:0] mbank [2][NLEDS];
  logic [23:0] cap [NLEDS];
  int          mfront = 0;
  bit          mpending = 0;
  bit          mbusy = 0;
  int          ntests = 0;
  int          nfail = 0;
  int          nwords = 0;
  int          fbase = 0;
  int          rmode = 0;
  logic        m_pv = 1'b0;
  logic        m_pr = 1'b0;
  logic [23:0] m_pg = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    ntests++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [7:0] sc(input logic [7:0] c, input int b);
    int v;
    v = (int'(c) * (b + 1)) / 256;
    return 8'(v);
  endfunction

  task automatic model_frame(input int b);
    exp_t e;
    logic [23:0] p;
    for (int i = 0; i < NLEDS; i++) begin
      p = mbank[mfront][i];
      e.idx  = 8'(i);
      e.last = (i == NLEDS - 1);
      e.grb  = {sc(p[15:8], b), sc(p[23:16], b), sc(p[7:0], b)};
      q.push_back(e);
    end
  endtask

  initial begin
    pix.pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rmode)
        0:       pix.pix_ready = 1'b1;
        1:       pix.pix_ready = ($urandom_range(0, 3) != 0);
        default: pix.pix_ready = 1'b0;
      endcase
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_pv = 1'b0;
      end else begin
        if (m_pv && !m_pr) begin
          chk("hold_valid", 32'(pix.pix_valid), 1);
          chk("hold_grb", 32'(pix.pix_grb), 32'(m_pg));
        end
        if (pix.pix_valid && pix.pix_ready) begin
          chk("word_expected", 32'(q.size() != 0), 1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("pix_grb", 32'(pix.pix_grb), 32'(e.grb));
            chk("pix_last", 32'(pix.pix_last), 32'(e.last));
            cap[e.idx[AW-1:0]] = pix.pix_grb;
          end
          nwords++;
        end
        m_pv = pix.pix_valid;
        m_pr = pix.pix_ready;
        m_pg = pix.pix_grb;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_pix(input int a, input logic [23:0] rgb);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_rgb  = rgb;
    tick();
    wr_en = 1'b0;
    mbank[1 - mfront][a] = rgb;
  endtask

  task automatic write_all_random();
    for (int i = 0; i < NLEDS; i++) write_pix(i, 24'($urandom));
  endtask

  task automatic do_commit(input bit with_wr, input int a,
                           input logic [23:0] rgb);
    commit = 1'b1;
    if (with_wr) begin
      wr_en   = 1'b1;
      wr_addr = AW'(a);
      wr_rgb  = rgb;
    end
    tick();
    commit = 1'b0;
    wr_en  = 1'b0;
    if (with_wr) mbank[1 - mfront][a] = rgb;
    chk("pending_set", 32'(commit_pending), 1);
    if (!mbusy) begin
      tick();
      chk("pending_swap_clear", 32'(commit_pending), 0);
      mfront = 1 - mfront;
    end else begin
      mpending = 1;
    end
  endtask

  task automatic start_frame();
    int n;
    fbase = nwords;
    mbusy = 1;
    model_frame(int'(brightness));
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n = 0;
    while (!pix.pix_valid && n < 12) begin
      tick();
      n++;
    end
    chk("first_valid_latency", n, 3);
  endtask

  task automatic wait_words(input int n);
    int k;
    k = 0;
    while (nwords - fbase < n && k < 3000) begin
      tick();
      k++;
    end
    chk("reach_word", 32'(nwords - fbase >= n), 1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || q.size() != 0) && k < 4000) begin
      tick();
      k++;
    end
    chk("frame_done_in_time", 32'(k < 4000), 1);
    chk("frame_words", nwords - fbase, NLEDS);
    mbusy = 0;
    if (mpending) begin
      chk("pending_held", 32'(commit_pending), 1);
      tick();
      chk("pending_cleared", 32'(commit_pending), 0);
      mfront   = 1 - mfront;
      mpending = 0;
    end
  endtask

  initial begin
    int k;
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(pix.pix_valid), 0);
    chk("rst_grb", 32'(pix.pix_grb), 0);
    chk("rst_last", 32'(pix.pix_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pending", 32'(commit_pending), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < NLEDS; i++)
      write_pix(i, {8'(i), 8'(2 * i), 8'(3 * i)});
    brightness = 8'd255;
    do_commit(0, 0, '0);
    start_frame();
    k = 0;
    while (!(nwords - fbase == 5 && pix.pix_valid) && k < 100) begin
      tick();
      k++;
    end
    rmode = 2;
    chk("bp_pixel5", 32'(pix.pix_grb), 32'h0A050F);
    repeat (10) begin
      tick();
      chk("bp_valid", 32'(pix.pix_valid), 1);
      chk("bp_busy", 32'(busy), 1);
      chk("bp_grb", 32'(pix.pix_grb), 32'h0A050F);
    end
    rmode = 0;
    wait_idle();
    chk("pattern_w63", 32'(cap[63]), 32'h7E3FBD);

    write_all_random();
    write_pix(0, 24'hC864FF);
    do_commit(0, 0, '0);
    brightness = 8'd127;
    start_frame();
    wait_idle();
    chk("b127_pixel0", 32'(cap[0]), 32'h32647F);
    brightness = 8'd0;
    start_frame();
    wait_idle();
    chk("b0_pixel0", 32'(cap[0]), 0);

    write_all_random();
    brightness = 8'd255;
    start_frame();
    wait_words(20);
    do_commit(0, 0, '0);
    wait_idle();
    start_frame();
    wait_idle();

    do_commit(1, 7, 24'hABCDEF);
    start_frame();
    wait_words(10);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_idle();
    chk("same_cycle_pixel7", 32'(cap[7]), 32'hCDABEF);
    repeat (6) tick();
    chk("no_queued_frame", 32'(busy), 0);
    chk("no_extra_words", nwords - fbase, NLEDS);

    write_all_random();
    do_commit(0, 0, '0);
    start_frame();
    wait_words(10);
    do_commit(0, 0, '0);
    wait_words(30);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(pix.pix_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_pending", 32'(commit_pending), 0);
    chk("abort_last", 32'(pix.pix_last), 0);
    q.delete();
    mfront   = 0;
    mpending = 0;
    mbusy    = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    start_frame();
    wait_idle();

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NLEDS; i++)
        if ($urandom_range(0, 1) != 0) write_pix(i, 24'($urandom));
      do_commit(0, 0, '0);
      brightness = 8'($urandom);
      rmode = 1;
      start_frame();
      brightness = 8'($urandom);
      wait_idle();
      rmode = 0;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/ws2812b_pixel_buffer.md
Name: ws2812b_pixel_buffer

Overview:
- Double-buffered frame store that sits directly upstream of the WS2812B bit serializer.
- Host logic writes RGB pixels into a back bank; a commit makes them visible at the next frame boundary.
- On each frame request from the serializer, the block streams NLEDS brightness-scaled 24-bit GRB words over a valid/ready handshake.

Parameters:
- NLEDS, 64, number of LEDs in the chain (pixels per frame).
- AW, 6, pixel address width; must satisfy 2**AW >= NLEDS.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- RESET_N  in  1  reset, asynchronous, active-low.
- wr_en  in  1  pixel write strobe.
- wr_addr  in  AW  pixel index to write.
- wr_rgb  in  24  pixel colour, packed {R,G,B}.
- commit  in  1  pulse: publish back bank at next frame boundary.
- brightness  in  8  global brightness; sampled at frame start.
- frame_start  in  1  pulse from serializer requesting a new frame.
- pix_valid  out  1  pix_grb holds a valid pixel.
- pix_ready  in  1  serializer accepts the pixel.
- pix_grb  out  24  scaled pixel, packed {G,R,B}.
- pix_last  out  1  marks pixel NLEDS-1.
- busy  out  1  frame streaming in progress.
- commit_pending  out  1  commit requested, swap not yet done.

Behaviour:
- Storage: one sync RAM of 2*NLEDS x 24; address MSB is the bank bit.
  - front = streamed bank; back = written bank.
  - Reset selects front = bank 0. RAM contents are not reset.
- Writes: wr_en with wr_addr < NLEDS writes back[wr_addr] on the clock edge. wr_addr >= NLEDS is ignored. Writes are accepted in every state.
- commit sets commit_pending. A commit while already pending has no further effect.
- Swap: occurs in the cycle where commit_pending=1 and the FSM is IDLE.
  - The swap clears commit_pending.
  - No copy is made; the new back bank holds the old front contents.
  - If wr_en and commit occur in the same cycle, the write lands in the pre-swap back bank, i.e. it is included in the commit.
- FSM states: IDLE, READ, SCALE, OUT.
  - IDLE: if frame_start=1 and no swap is occurring this cycle: latch brightness, set idx=0, go READ, busy=1. If a swap occurs in the same cycle, frame_start is honoured one cycle later; the request is held internally, not dropped.
  - READ: present front[idx] to RAM, go SCALE.
  - SCALE: register the RAM data through the multiplier, go OUT.
  - OUT: pix_valid=1; pix_grb and pix_last stay stable until pix_ready=1.
    - On handshake with idx=NLEDS-1: go IDLE, busy=0.
    - Otherwise: idx+1, go READ.
- Latency:
  - First pix_valid is asserted 3 edges after the frame_start edge.
  - After each handshake, the next pix_valid follows 3 edges later.
  - pix_ready held high gives one pixel every 4 cycles.
- Scaling: per channel, out = (c * (brightness_latched + 1)) >> 8, using a 16-bit product and taking bits [15:8].
  - brightness 255 gives identity; brightness 0 gives all channels 0.
- Packing: pix_grb = {G',R',B'}. pix_last=1 only while pixel NLEDS-1 is valid.
- frame_start while busy=1 is ignored and not queued.
- pix_ready while pix_valid=0 is ignored.
- Reset values:
  - pix_valid=0, pix_grb=0, pix_last=0, busy=0, commit_pending=0.
  - FSM=IDLE, idx=0, front=bank 0.
- Reset mid-frame aborts immediately; outputs return to reset values asynchronously.

Decomposition:
- Package ws2812b_pkg: NLEDS, AW, the GRB packing function, the FSM state encoding, and the WS2812B timing constants shared with the serializer.
- Sub-module ws2812b_dpram: simple dual-port, 1 write / 1 read, 1-cycle registered read, depth 2*NLEDS, width 24.

Test Plan:
- Reset, then write pixel i = {R=i,G=2i,B=3i} for all 64, commit, frame_start, brightness=255, pix_ready=1 -> 64 words, word i = {2i,i,3i} (8-bit wrap); pix_last only on word 63; first pix_valid 3 cycles after frame_start.
- brightness=127, pixel {R=200,G=100,B=255} -> pix_grb = {50,100,127}; brightness=0 -> 0x000000.
- Backpressure: pix_ready low for 10 cycles during pixel 5 -> pix_valid and pix_grb held constant; no pixel lost or duplicated; busy stays 1.
- Commit mid-frame: frame streaming bank 0, commit at pixel 20 -> current frame completes entirely from old data; commit_pending=1 until busy falls, then clears; next frame shows new data.
- Same-cycle wr_en(addr 7, 0xABCDEF) + commit while IDLE, then frame_start -> pixel 7 = {0xCD,0xAB,0xEF}; wr_addr=64 ignored; frame_start during busy ignored (exactly 64 words).
- RESET_N low at pixel 30 -> pix_valid, busy, commit_pending are 0 immediately; after release, the next frame starts at pixel 0 from bank 0.
